// File: rtl/fifo_uart_tx.sv
// 8N1 serial transmitter that drains an upstream FIFO one byte per frame.
// Pops with a one-cycle registered strobe and shifts each byte out LSB first.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] fifo_cnt,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shift_q, shift_nxt;
    logic          tx_nxt;
    logic          rd_nxt;
    logic          bit_end;
    logic          can_pop;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign can_pop = en && (fifo_cnt != 4'd0);
    assign busy    = (state != IDLE);
    assign tx_done = (state == STOP) && bit_end;

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift_q;
        tx_nxt    = tx;
        rd_nxt    = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (can_pop) begin
                    state_nxt = POP;
                    rd_nxt    = 1'b1;
                end
            end
            POP: state_nxt = LOAD;
            // FIFO read data is valid here, one edge after the strobe was sampled
            LOAD: begin
                shift_nxt = fifo_data;
                tx_nxt    = 1'b0;
                baud_nxt  = '0;
                state_nxt = START;
            end
            START: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    tx_nxt    = shift_q[0];
                    bit_nxt   = 3'd0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        shift_nxt = {1'b0, shift_q[7:1]};
                        tx_nxt    = shift_q[1];
                        bit_nxt   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end
            // Chaining straight into POP keeps the gap between frames at two cycles
            STOP: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    if (can_pop) begin
                        state_nxt = POP;
                        rd_nxt    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx       <= 1'b1;
            fifo_rd  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            tx       <= tx_nxt;
            fifo_rd  <= rd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_nxt;
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural FIFO and a bit-level frame receiver.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int FL  = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [3:0] fifo_cnt = 4'd5;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic [7:0] mem [0:15];
    int rd_ptr = 0;
    int pops = 0;
    int rd_viol = 0;
    logic prev_rd = 1'b0;

    int errors = 0;
    int checks = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_cnt(fifo_cnt), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge and act as the FIFO for any pending read
    task automatic step();
        @(negedge clk);
        if (fifo_rd === 1'b1) begin
            if (fifo_cnt == 4'd0 || prev_rd) rd_viol++;
            fifo_data = mem[rd_ptr[3:0]];
            rd_ptr++;
            pops++;
            if (fifo_cnt != 4'd0) fifo_cnt = fifo_cnt - 4'd1;
        end
        prev_rd = (fifo_rd === 1'b1);
    endtask

    task automatic fifo_load(input int n, input int base, input int inc);
        rd_ptr = 0;
        pops = 0;
        for (int i = 0; i < n; i++) mem[i] = 8'(base + i * inc);
        fifo_cnt = 4'(n);
    endtask

    // Wait for a start bit, then sample one complete frame cycle by cycle
    task automatic capture(input bit drop_en, output logic [7:0] b, output bit ok,
                           output int done_cyc, output int done_n, output int pre_hi,
                           output bit seen);
        logic lv [1:FL];
        pre_hi = 0; seen = 0; done_n = 0; done_cyc = 0; ok = 1'b1; b = 8'h00;
        for (int w = 0; w < 2000; w++) begin
            step();
            if (tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
            if (tx_done === 1'b1) pre_hi = 0;
            else if (tx === 1'b1) pre_hi++;
        end
        if (!seen) return;
        if (drop_en) en = 1'b0;
        for (int k = 1; k <= FL; k++) begin
            if (k > 1) step();
            lv[k] = tx;
            if (tx_done === 1'b1) begin
                done_n++;
                done_cyc = k;
            end
        end
        for (int g = 0; g < 10; g++)
            for (int j = 1; j < CPB; j++)
                if (lv[g*CPB + j + 1] !== lv[g*CPB + 1]) ok = 1'b0;
        if (lv[1] !== 1'b0 || lv[9*CPB + 1] !== 1'b1) ok = 1'b0;
        for (int i = 0; i < 8; i++) b[i] = lv[(i + 1) * CPB + 1];
    endtask

    task automatic test_reset();
        logic [7:0] b; bit ok, seen; int dc, dn, ph;
        fifo_load(5, 8'h40, 1);
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx cyc%0d got=%b exp=1", c, tx); end
            checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd cyc%0d got=%b exp=0", c, fifo_rd); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc%0d got=%b exp=0", c, busy); end
            checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done cyc%0d got=%b exp=0", c, tx_done); end
        end
        rst = 1'b0;
        step();
        checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL first_rd got=%b exp=1", fifo_rd); end
        en = 1'b0;
        capture(1'b0, b, ok, dc, dn, ph, seen);
        checks++; if (b !== 8'h40 || !ok || !seen) begin errors++; $display("FAIL reset_frame got=%h ok=%0d exp=40", b, ok); end
        for (int c = 0; c < 5; c++) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
        fifo_cnt = 4'd0;
    endtask

    task automatic test_single();
        logic [7:0] b; bit ok, seen; int dc, dn, ph;
        fifo_load(1, 8'hA5, 0);
        en = 1'b1;
        capture(1'b0, b, ok, dc, dn, ph, seen);
        checks++; if (!seen) begin errors++; $display("FAIL single_start got=none exp=start"); end
        checks++; if (b !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", b); end
        checks++; if (!ok) begin errors++; $display("FAIL single_levels got=unstable exp=held %0d", CPB); end
        checks++; if (dn !== 1 || dc !== FL) begin errors++; $display("FAIL single_done got=%0d@%0d exp=1@%0d", dn, dc, FL); end
        for (int c = 0; c < 5; c++) step();
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_idle got busy=%b tx=%b exp busy=0 tx=1", busy, tx); end
        checks++; if (pops !== 1) begin errors++; $display("FAIL single_pops got=%0d exp=1", pops); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b; bit ok, seen; int dc, dn, ph;
        fifo_load(8, 0, 5);
        for (int i = 0; i < 8; i++) begin
            capture(1'b0, b, ok, dc, dn, ph, seen);
            checks++; if (b !== 8'(i * 5) || !ok || !seen) begin errors++; $display("FAIL drain_data%0d got=%h ok=%0d exp=%h", i, b, ok, 8'(i * 5)); end
            checks++; if (dn !== 1 || dc !== FL) begin errors++; $display("FAIL drain_done%0d got=%0d@%0d exp=1@%0d", i, dn, dc, FL); end
            if (i > 0) begin
                checks++; if (ph !== 2) begin errors++; $display("FAIL drain_gap%0d got=%0d exp=2", i, ph); end
            end
        end
        for (int c = 0; c < 50; c++) step();
        checks++; if (pops !== 8) begin errors++; $display("FAIL drain_pops got=%0d exp=8", pops); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy got=%b exp=0", busy); end
        checks++; if (rd_viol !== 0) begin errors++; $display("FAIL drain_rd_safety got=%0d exp=0", rd_viol); end
    endtask

    task automatic test_empty();
        int nrd = 0, nlow = 0, nbusy = 0;
        fifo_cnt = 4'd0;
        en = 1'b1;
        for (int c = 0; c < 200; c++) begin
            step();
            if (fifo_rd !== 1'b0) nrd++;
            if (tx !== 1'b1) nlow++;
            if (busy !== 1'b0) nbusy++;
        end
        checks++; if (nrd !== 0) begin errors++; $display("FAIL empty_rd got=%0d exp=0", nrd); end
        checks++; if (nlow !== 0) begin errors++; $display("FAIL empty_tx got=%0d exp=0", nlow); end
        checks++; if (nbusy !== 0) begin errors++; $display("FAIL empty_busy got=%0d exp=0", nbusy); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b; bit ok, seen; int dc, dn, ph;
        int ndone = 0, nlow = 0;
        bit found = 0;
        fifo_load(1, 8'h81, 0);
        en = 1'b1;
        for (int w = 0; w < 200; w++) begin
            step();
            if (tx === 1'b0) begin found = 1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_start got=none exp=start"); end
        for (int c = 0; c < 5 * CPB - 2; c++) step();
        rst = 1'b1;
        step();
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset got tx=%b busy=%b exp tx=1 busy=0", tx, busy); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL mid_reset_done got=%b exp=0", tx_done); end
        rst = 1'b0;
        for (int c = 0; c < FL; c++) begin
            step();
            if (tx_done !== 1'b0) ndone++;
            if (tx !== 1'b1) nlow++;
        end
        checks++; if (ndone !== 0 || nlow !== 0) begin errors++; $display("FAIL mid_after got done=%0d low=%0d exp 0 0", ndone, nlow); end
        mem[rd_ptr[3:0]] = 8'h3C;
        fifo_cnt = 4'd1;
        capture(1'b0, b, ok, dc, dn, ph, seen);
        checks++; if (b !== 8'h3C || !ok || !seen) begin errors++; $display("FAIL mid_next got=%h ok=%0d exp=3c", b, ok); end
        checks++; if (dn !== 1 || dc !== FL) begin errors++; $display("FAIL mid_next_done got=%0d@%0d exp=1@%0d", dn, dc, FL); end
    endtask

    task automatic test_enable();
        logic [7:0] b; bit ok, seen; int dc, dn, ph;
        fifo_load(3, 8'h11, 8'h11);
        en = 1'b1;
        capture(1'b1, b, ok, dc, dn, ph, seen);
        checks++; if (b !== 8'h11 || !ok || !seen) begin errors++; $display("FAIL en_frame1 got=%h ok=%0d exp=11", b, ok); end
        checks++; if (dn !== 1 || dc !== FL) begin errors++; $display("FAIL en_done1 got=%0d@%0d exp=1@%0d", dn, dc, FL); end
        for (int c = 0; c < 30; c++) step();
        checks++; if (pops !== 1 || busy !== 1'b0) begin errors++; $display("FAIL en_hold got pops=%0d busy=%b exp 1 0", pops, busy); end
        en = 1'b1;
        step();
        checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL en_resume got=%b exp=1", fifo_rd); end
        capture(1'b0, b, ok, dc, dn, ph, seen);
        checks++; if (b !== 8'h22 || !ok || !seen) begin errors++; $display("FAIL en_frame2 got=%h exp=22", b); end
        capture(1'b0, b, ok, dc, dn, ph, seen);
        checks++; if (b !== 8'h33 || !ok || !seen) begin errors++; $display("FAIL en_frame3 got=%h exp=33", b); end
        for (int c = 0; c < 10; c++) step();
        checks++; if (pops !== 3 || rd_viol !== 0) begin errors++; $display("FAIL en_pops got=%0d viol=%0d exp 3 0", pops, rd_viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_empty();
        test_reset_midframe();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
